// File: rtl/switch_out_allocator_6.sv
// Per-output-port allocator: round-robin arbitration among six inputs with a
// wormhole lock on the crossbar select that holds until the tail flit transfers.
module switch_out_allocator_6 #(
   parameter int N_IN          = 6,
   parameter int PTR_W         = 3,
   parameter int CNT_W         = 8,
   parameter int MAX_PKT_FLITS = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_IN-1:0] req,
   input  logic [N_IN-1:0] flit_valid,
   input  logic [N_IN-1:0] flit_tail,
   input  logic            out_ready,
   output logic [N_IN-1:0] mux_sel,
   output logic [N_IN-1:0] flit_accept,
   output logic            out_valid,
   output logic            busy,
   output logic            err_long_pkt
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state_q, state_d;
   logic [N_IN-1:0]     mux_sel_q, mux_sel_d;
   logic                busy_q, busy_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    flit_cnt_q, flit_cnt_d;
   logic                err_q, err_d;

   logic                winnerValid;
   logic [PTR_W-1:0]    winnerIdx;
   logic [PTR_W:0]      scanIdx;
   logic [PTR_W-1:0]    ownerIdx;
   logic [PTR_W-1:0]    ownerNext;
   logic                transfer;
   logic                tailXfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mux_sel_q  <= '0;
         busy_q     <= 1'b0;
         rr_ptr_q   <= '0;
         flit_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mux_sel_q  <= mux_sel_d;
         busy_q     <= busy_d;
         rr_ptr_q   <= rr_ptr_d;
         flit_cnt_q <= flit_cnt_d;
         err_q      <= err_d;
      end
   end

   // First requester at or above the pointer, wrapping past the last input.
   always_comb begin
      winnerValid = 1'b0;
      winnerIdx   = '0;
      scanIdx     = '0;
      for (int k = 0; k < N_IN; k++) begin
         scanIdx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scanIdx >= (PTR_W+1)'(N_IN)) begin
            scanIdx = scanIdx - (PTR_W+1)'(N_IN);
         end
         if (!winnerValid && req[scanIdx[PTR_W-1:0]]) begin
            winnerValid = 1'b1;
            winnerIdx   = scanIdx[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      ownerIdx = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (mux_sel_q[k]) begin
            ownerIdx = PTR_W'(k);
         end
      end
      ownerNext = (ownerIdx == PTR_W'(N_IN - 1)) ? '0 : ownerIdx + PTR_W'(1);
   end

   always_comb begin
      flit_accept = mux_sel_q & flit_valid & {N_IN{out_ready}};
      out_valid   = |(mux_sel_q & flit_valid);
      transfer    = |flit_accept;
      tailXfer    = |(flit_accept & flit_tail);
   end

   // Pointer advances only on release; the tail cycle itself never arbitrates.
   always_comb begin
      state_d    = state_q;
      mux_sel_d  = mux_sel_q;
      busy_d     = busy_q;
      rr_ptr_d   = rr_ptr_q;
      flit_cnt_d = flit_cnt_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (winnerValid) begin
               state_d    = LOCKED;
               mux_sel_d  = N_IN'(1) << winnerIdx;
               busy_d     = 1'b1;
               flit_cnt_d = '0;
            end
         end
         LOCKED: begin
            if (transfer) begin
               if (flit_cnt_q != '1) begin
                  flit_cnt_d = flit_cnt_q + CNT_W'(1);
               end
               if (!tailXfer && (flit_cnt_q >= CNT_W'(MAX_PKT_FLITS))) begin
                  err_d = 1'b1;
               end
               if (tailXfer) begin
                  state_d   = IDLE;
                  mux_sel_d = '0;
                  busy_d    = 1'b0;
                  rr_ptr_d  = ownerNext;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mux_sel_d = '0;
            busy_d    = 1'b0;
         end
      endcase
   end

   assign mux_sel      = mux_sel_q;
   assign busy         = busy_q;
   assign err_long_pkt = err_q;

endmodule

// File: tb/tb_switch_out_allocator_6.sv
// Directed bench for switch_out_allocator_6: arbitration, wormhole lock,
// stalls, rotation, async reset and long-packet error.
module tb_switch_out_allocator_6;

   logic       clk;
   logic       rst;
   logic [5:0] req;
   logic [5:0] flit_valid;
   logic [5:0] flit_tail;
   logic       out_ready;
   logic [5:0] mux_sel;
   logic [5:0] flit_accept;
   logic       out_valid;
   logic       busy;
   logic       err_long_pkt;

   int compared;
   int mismatched;

   switch_out_allocator_6 dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .flit_valid   (flit_valid),
      .flit_tail    (flit_tail),
      .out_ready    (out_ready),
      .mux_sel      (mux_sel),
      .flit_accept  (flit_accept),
      .out_valid    (out_valid),
      .busy         (busy),
      .err_long_pkt (err_long_pkt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] r, input logic [5:0] v, input logic [5:0] t, input logic rdy);
      req        = r;
      flit_valid = v;
      flit_tail  = t;
      out_ready  = rdy;
      #1;
   endtask

   // Advance to just past the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      req        = '0;
      flit_valid = '0;
      flit_tail  = '0;
      out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("reset_mux_sel", 32'(mux_sel), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_err", 32'(err_long_pkt), 32'h0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'h0);

      // Test 1: first grant from pointer 0 goes to input 3, one cycle later
      applyStimulus(6'b101000, 6'b000000, 6'b000000, 1'b1);
      checkOutput("t1_latency_mux_sel", 32'(mux_sel), 32'h0);
      nextCycle();
      checkOutput("t1_grant_mux_sel", 32'(mux_sel), 32'h08);
      checkOutput("t1_grant_busy", 32'(busy), 32'h1);

      // Test 2: four-flit packet, non-owner valid/tail bits set as noise
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(6'b101000, 6'b111111, (i == 4) ? 6'b001000 : 6'b110111, 1'b1);
         checkOutput($sformatf("t2_accept_%0d", i), 32'(flit_accept), 32'h08);
         checkOutput($sformatf("t2_out_valid_%0d", i), 32'(out_valid), 32'h1);
         nextCycle();
      end
      checkOutput("t2_bubble_mux_sel", 32'(mux_sel), 32'h0);
      checkOutput("t2_bubble_busy", 32'(busy), 32'h0);
      checkOutput("t2_bubble_accept", 32'(flit_accept), 32'h0);
      nextCycle();
      checkOutput("t2_next_grant", 32'(mux_sel), 32'h20);

      // Test 3: owner 5 stalls on out_ready while its req drops
      applyStimulus(6'b101000, 6'b100000, 6'b000000, 1'b1);
      checkOutput("t3_first_accept", 32'(flit_accept), 32'h20);
      nextCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'b001000, 6'b111111, 6'b000000, 1'b0);
         checkOutput($sformatf("t3_stall_accept_%0d", i), 32'(flit_accept), 32'h0);
         checkOutput($sformatf("t3_stall_valid_%0d", i), 32'(out_valid), 32'h1);
         nextCycle();
         checkOutput($sformatf("t3_stall_mux_sel_%0d", i), 32'(mux_sel), 32'h20);
      end
      applyStimulus(6'b000000, 6'b100000, 6'b100000, 1'b1);
      checkOutput("t3_resume_accept", 32'(flit_accept), 32'h20);
      nextCycle();
      checkOutput("t3_release_mux_sel", 32'(mux_sel), 32'h0);

      // Test 4: rotation with single-flit packets from every input
      applyStimulus(6'b111111, 6'b111111, 6'b111111, 1'b1);
      for (int g = 0; g < 7; g++) begin
         nextCycle();
         checkOutput($sformatf("t4_grant_%0d", g), 32'(mux_sel), 32'(6'b1 << (g % 6)));
         checkOutput($sformatf("t4_accept_%0d", g), 32'(flit_accept), 32'(6'b1 << (g % 6)));
         nextCycle();
         checkOutput($sformatf("t4_bubble_%0d", g), 32'(mux_sel), 32'h0);
      end
      applyStimulus(6'b000000, 6'b000000, 6'b000000, 1'b1);

      // Test 5: reset mid-packet drops the lock without a clock edge
      applyStimulus(6'b000100, 6'b000000, 6'b000000, 1'b1);
      nextCycle();
      checkOutput("t5_grant", 32'(mux_sel), 32'h04);
      applyStimulus(6'b000100, 6'b000100, 6'b000000, 1'b1);
      nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("t5_async_mux_sel", 32'(mux_sel), 32'h0);
      checkOutput("t5_async_busy", 32'(busy), 32'h0);
      #2;
      rst = 1'b0;
      applyStimulus(6'b000010, 6'b000000, 6'b000000, 1'b1);
      nextCycle();
      checkOutput("t5_regrant", 32'(mux_sel), 32'h02);

      // Test 6: 66 non-tail flits trip the long-packet flag on transfer 65
      for (int i = 1; i <= 66; i++) begin
         applyStimulus(6'b000010, 6'b000010, 6'b000000, 1'b1);
         nextCycle();
         if (i >= 64) begin
            checkOutput($sformatf("t6_err_after_%0d", i), 32'(err_long_pkt), (i >= 65) ? 32'h1 : 32'h0);
         end
      end
      checkOutput("t6_lock_held", 32'(mux_sel), 32'h02);
      applyStimulus(6'b000010, 6'b000010, 6'b000010, 1'b1);
      checkOutput("t6_tail_accept", 32'(flit_accept), 32'h02);
      nextCycle();
      checkOutput("t6_release_busy", 32'(busy), 32'h0);
      checkOutput("t6_err_sticky", 32'(err_long_pkt), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/switch_out_allocator_6.md
Name: switch_out_allocator_6

Overview:
Per-output-port allocator for the 6-input switch crossbar.
- Arbitrates among the six input ports whose head flits target this output, using rotating (round-robin) priority.
- Drives the one-hot select of the 6:1 80-bit crossbar multiplexer and holds it for the whole packet (wormhole lock) until the tail flit transfers.
- One instance per switch output port, between the input-port routing logic and the crossbar mux.

Parameters:
N_IN, 6, number of input ports; fixed to 6 to match the 6-bit one-hot mux select.
PTR_W, 3, width of the round-robin pointer.
CNT_W, 8, width of the per-packet flit counter.
MAX_PKT_FLITS, 64, flit count above which err_long_pkt sets.

Ports:
clk  in  1  switch clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  6  bit i: input i has a routed head flit destined to this output.
flit_valid  in  6  bit i: input i presents a valid flit.
flit_tail  in  6  bit i: the flit at input i is a tail flit. A single-flit packet has head=tail.
out_ready  in  1  downstream (output buffer/link) accepts a flit this cycle.
mux_sel  out  6  one-hot crossbar select; 0 when no packet is owned. Registered.
flit_accept  out  6  bit i pulses when input i's flit transfers; combinational.
out_valid  out  1  valid flit on crossbar output; combinational.
busy  out  1  a packet currently owns the output. Registered.
err_long_pkt  out  1  sticky: a packet exceeded MAX_PKT_FLITS. Cleared only by rst.

Behaviour:
Reset (async, rst=1): state=IDLE, mux_sel=0, busy=0, rr_ptr=0, flit_cnt=0, err_long_pkt=0. flit_accept and out_valid read 0 because mux_sel=0.

States and transitions:
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: winner = first set req bit scanning from rr_ptr upward with wrap 5->0. Next edge: mux_sel=onehot(winner), busy=1, flit_cnt=0, state=LOCKED.
- Arbitration latency: req to mux_sel is exactly 1 cycle.
- LOCKED: owner = index of mux_sel.
  - out_valid = |(mux_sel & flit_valid).
  - flit_accept = mux_sel & flit_valid & {6{out_ready}}; at most one bit set.
  - Transfer = any flit_accept bit. Each transfer increments flit_cnt, saturating at all-ones.
  - Transfer with flit_tail[owner]=1: next edge mux_sel=0, busy=0, rr_ptr=(owner+1) mod 6, state=IDLE.
  - Release leaves one idle bubble cycle; no arbitration happens in the tail cycle.
- If flit_cnt reaches MAX_PKT_FLITS and another non-tail flit transfers, err_long_pkt sets. The lock is held regardless.

Boundary rules:
- Owner stalls: no valid flit or out_ready=0 → hold lock, no transfer, flit_cnt unchanged.
- Owner's req deasserts mid-packet: ignored; only the tail transfer releases.
- req bits of other inputs while LOCKED: ignored. They are serviced after release by the pointer rules.
- flit_valid/flit_tail of non-owners: never affect outputs.
- Single-flit packet: one LOCKED cycle with transfer, then IDLE.
- rr_ptr wraps 5 → 0. rr_ptr updates only on tail transfer, never on grant.
- rst asserted mid-packet: immediate return to reset values, lock dropped, rr_ptr=0. Whole-packet recovery is upstream's responsibility.
- mux_sel is always 0 or exactly one-hot. The mux default (0) is therefore only seen when idle.

Test Plan:
1. After reset, req=6'b101000 → IDLE. Next cycle mux_sel=6'b001000. Winner is input 3 because rr_ptr=0 and bit 3 is the first set bit from 0. busy=1.
2. Owner input 3 sends 4 flits with out_ready=1, tail on the 4th → flit_accept[3] pulses 4 cycles. mux_sel=0 the cycle after the tail; rr_ptr=4. With req=6'b101000 still held, the next grant goes to input 5 (6'b100000).
3. Owner mid-packet with out_ready=0 for 3 cycles → flit_accept=0, out_valid=1, mux_sel held, flit_cnt unchanged. Transfer resumes when out_ready=1.
4. Rotation: all req=6'b111111 with single-flit packets → grants in order 0,1,2,3,4,5,0, each occupying 2 cycles (grant + bubble).
5. Assert rst during cycle 2 of a 5-flit packet → mux_sel=0 and busy=0 immediately, without waiting for a clock edge. After release, req=6'b000010 → grant input 1.
6. Owner sends 66 non-tail flits → err_long_pkt=1 from the 65th transfer. The lock is held until the tail, and err stays 1 after release.
